// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the Mini SRC datapath: opcodes, bus/enable
// bit positions, ALU select codes and the sequencer step encoding.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Same bit position in both the bus-source one-hot and the load enables
    localparam int IDX_Z   = 19;
    localparam int IDX_PC  = 20;
    localparam int IDX_IR  = 21;
    localparam int IDX_MDR = 22;
    localparam int IDX_MAR = 23;
    localparam int IDX_Y   = 24;
    localparam int IDX_C   = 25;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_AND = 6'd2;
    localparam logic [5:0] ALU_OR  = 6'd3;

    typedef enum logic [3:0] {
        ST_T0         = 4'd0,
        ST_T1         = 4'd1,
        ST_T2         = 4'd2,
        ST_T3         = 4'd3,
        ST_T4         = 4'd4,
        ST_T5         = 4'd5,
        ST_T6         = 4'd6,
        ST_T7         = 4'd7,
        ST_RESET_IDLE = 4'd8,
        ST_HALT       = 4'd9
    } step_t;

    function automatic logic [5:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (step, latched opcode, con_ff) to the datapath
// control vector; instr_done marks the final step of each instruction.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  step_t          step,
    input  logic [4:0]     opcode,
    input  logic           con_ff,
    output logic [W-1:0]   enc_input,
    output logic [W-1:0]   reg_enable,
    output logic [5:0]     alu_sel,
    output logic           read,
    output logic           write,
    output logic           inc_pc,
    output logic           gra,
    output logic           grb,
    output logic           grc,
    output logic           rin,
    output logic           rout,
    output logic           ba_out,
    output logic           con_in,
    output logic           instr_done,
    output logic           halted
);

    // Step/opcode decode; unreachable combinations end the instruction so
    // the sequencer always falls back to fetch.
    always_comb begin
        enc_input  = '0;
        reg_enable = '0;
        alu_sel    = ALU_ADD;
        read       = 1'b0;
        write      = 1'b0;
        inc_pc     = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        rin        = 1'b0;
        rout       = 1'b0;
        ba_out     = 1'b0;
        con_in     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (step)
            ST_T0: begin
                enc_input[IDX_PC]   = 1'b1;
                reg_enable[IDX_MAR] = 1'b1;
                inc_pc              = 1'b1;
            end
            ST_T1: begin
                read                = 1'b1;
                reg_enable[IDX_MDR] = 1'b1;
            end
            ST_T2: begin
                enc_input[IDX_MDR] = 1'b1;
                reg_enable[IDX_IR] = 1'b1;
            end
            ST_T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        grb               = 1'b1;
                        rout              = 1'b1;
                        reg_enable[IDX_Y] = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        grb               = 1'b1;
                        ba_out            = 1'b1;
                        reg_enable[IDX_Y] = 1'b1;
                    end
                    OP_BR: begin
                        gra    = 1'b1;
                        rout   = 1'b1;
                        con_in = 1'b1;
                    end
                    OP_JR: begin
                        gra                = 1'b1;
                        rout               = 1'b1;
                        reg_enable[IDX_PC] = 1'b1;
                        instr_done         = 1'b1;
                    end
                    OP_JAL: begin
                        enc_input[IDX_PC] = 1'b1;
                        grb               = 1'b1;
                        rin               = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        grc               = 1'b1;
                        rout              = 1'b1;
                        alu_sel           = alu_code(opcode);
                        reg_enable[IDX_Z] = 1'b1;
                    end
                    OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                        enc_input[IDX_C]  = 1'b1;
                        alu_sel           = ALU_ADD;
                        reg_enable[IDX_Z] = 1'b1;
                    end
                    OP_BR: begin
                        enc_input[IDX_PC] = 1'b1;
                        reg_enable[IDX_Y] = 1'b1;
                    end
                    OP_JAL: begin
                        gra                = 1'b1;
                        rout               = 1'b1;
                        reg_enable[IDX_PC] = 1'b1;
                        instr_done         = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
                        enc_input[IDX_Z] = 1'b1;
                        gra              = 1'b1;
                        rin              = 1'b1;
                        instr_done       = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        enc_input[IDX_Z]    = 1'b1;
                        reg_enable[IDX_MAR] = 1'b1;
                    end
                    OP_BR: begin
                        enc_input[IDX_C]  = 1'b1;
                        alu_sel           = ALU_ADD;
                        reg_enable[IDX_Z] = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T6: begin
                case (opcode)
                    OP_LD: begin
                        read                = 1'b1;
                        reg_enable[IDX_MDR] = 1'b1;
                    end
                    OP_ST: begin
                        gra                 = 1'b1;
                        rout                = 1'b1;
                        reg_enable[IDX_MDR] = 1'b1;
                    end
                    OP_BR: begin
                        // Branch taken only when the CON FF latched true at T3
                        if (con_ff) begin
                            enc_input[IDX_Z]   = 1'b1;
                            reg_enable[IDX_PC] = 1'b1;
                        end else begin
                            enc_input  = '0;
                            reg_enable = '0;
                        end
                        instr_done = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OP_LD: begin
                        enc_input[IDX_MDR] = 1'b1;
                        gra                = 1'b1;
                        rin                = 1'b1;
                    end
                    OP_ST: write = 1'b1;
                    default: ;
                endcase
                instr_done = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: holds the step and opcode registers and
// the HALT/reset sequencing; the control vector comes from ctrl_decode.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clr,
    input  logic [31:0]  ir,
    input  logic         con_ff,
    output logic [W-1:0] enc_input,
    output logic [W-1:0] reg_enable,
    output logic [5:0]   ALU_Sel,
    output logic         read,
    output logic         write,
    output logic         incPC,
    output logic         Gra,
    output logic         Grb,
    output logic         Grc,
    output logic         Rin,
    output logic         Rout,
    output logic         BAout,
    output logic         conIn,
    output logic         instr_done,
    output logic         halted
);

    step_t      step_r;
    logic [4:0] opcode_r;
    logic       armed_r;
    logic       done_s;
    logic       unused_ir_s;

    assign unused_ir_s = ^ir[26:0];
    assign instr_done  = done_s;

    // Step sequencing; RESET_IDLE waits one extra cycle after clr releases
    always_ff @(posedge clock) begin
        if (!clr) begin
            step_r   <= ST_RESET_IDLE;
            opcode_r <= OP_NOP;
            armed_r  <= 1'b0;
        end else begin
            case (step_r)
                ST_RESET_IDLE: begin
                    if (armed_r) begin
                        step_r <= ST_T0;
                    end else begin
                        armed_r <= 1'b1;
                    end
                end
                ST_HALT: step_r <= ST_HALT;
                ST_T2: begin
                    opcode_r <= ir[31:27];
                    step_r   <= (ir[31:27] == OP_HALT) ? ST_HALT : ST_T3;
                end
                ST_T7: step_r <= ST_T0;
                default: step_r <= done_s ? ST_T0 : step_t'(step_r + 4'd1);
            endcase
        end
    end

    ctrl_decode #(.W(W)) u_decode (
        .step       (step_r),
        .opcode     (opcode_r),
        .con_ff     (con_ff),
        .enc_input  (enc_input),
        .reg_enable (reg_enable),
        .alu_sel    (ALU_Sel),
        .read       (read),
        .write      (write),
        .inc_pc     (incPC),
        .gra        (Gra),
        .grb        (Grb),
        .grc        (Grc),
        .rin        (Rin),
        .rout       (Rout),
        .ba_out     (BAout),
        .con_in     (conIn),
        .instr_done (done_s),
        .halted     (halted)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, fetch, ALU, br, jal, st with
// mid-instruction reset, halt, and undefined-opcode handling.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int W = 32;
    localparam logic [31:0] PC_B  = 32'h0010_0000;
    localparam logic [31:0] MAR_B = 32'h0080_0000;
    localparam logic [31:0] Z_B   = 32'h0008_0000;
    localparam logic [31:0] MDR_B = 32'h0040_0000;
    localparam logic [31:0] IR_B  = 32'h0020_0000;
    localparam logic [31:0] Y_B   = 32'h0100_0000;
    localparam logic [31:0] C_B   = 32'h0200_0000;

    typedef struct packed {
        logic [31:0] enc;
        logic [31:0] ren;
        logic [5:0]  alu;
        logic rd, wr, inc, gra, grb, grc, rin, rout, baout, conin, done, halted;
    } snap_t;

    logic         clock = 1'b0;
    logic         clr;
    logic [31:0]  ir;
    logic         con_ff;
    logic [W-1:0] enc_input, reg_enable;
    logic [5:0]   ALU_Sel;
    logic read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, instr_done, halted;

    snap_t cur_s;
    snap_t snap [0:15];
    int    n_checks = 0;
    int    n_fail   = 0;

    assign cur_s = {enc_input, reg_enable, ALU_Sel, read, write, incPC, Gra, Grb, Grc,
                    Rin, Rout, BAout, conIn, instr_done, halted};

    always #5 clock = ~clock;

    control_sequencer #(.W(W)) dut (
        .clock(clock), .clr(clr), .ir(ir), .con_ff(con_ff),
        .enc_input(enc_input), .reg_enable(reg_enable), .ALU_Sel(ALU_Sel),
        .read(read), .write(write), .incPC(incPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .conIn(conIn),
        .instr_done(instr_done), .halted(halted)
    );

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction from T0, recording each step, then checks length and return to T0
    task automatic run_instr(input logic [4:0] op, input logic cf, input int exp_len, input string tag);
        int n;
        ir     = {op, 27'h0};
        con_ff = cf;
        snap[0] = cur_s;
        n = 1;
        while (!snap[n-1].done && n < 16) begin
            tick();
            snap[n] = cur_s;
            n++;
        end
        check({tag, "_len"}, 96'(n), 96'(exp_len));
        tick();
        check({tag, "_next_t0"}, {cur_s.enc, cur_s.ren, cur_s.inc}, {PC_B, MAR_B, 1'b1});
    endtask

    initial begin
        int wr_seen;
        int hc;
        clr = 1'b0; ir = 32'h0; con_ff = 1'b0;

        tick(); tick();
        check("reset_outputs", cur_s, 96'h0);
        clr = 1'b1;
        tick();
        check("post_release_idle", cur_s, 96'h0);
        tick();
        check("first_t0", {cur_s.enc, cur_s.ren, cur_s.inc}, {PC_B, MAR_B, 1'b1});

        // add R1,R2,R3 with ir changed after T3 to prove the opcode is latched
        ir = 32'h1800_0000;
        tick();
        check("add_t1", {cur_s.rd, cur_s.ren, cur_s.enc}, {1'b1, MDR_B, 32'h0});
        tick();
        check("add_t2", {cur_s.enc, cur_s.ren}, {MDR_B, IR_B});
        tick();
        ir = {OP_HALT, 27'h0};
        check("add_t3", {cur_s.grb, cur_s.rout, cur_s.ren, cur_s.enc}, {1'b1, 1'b1, Y_B, 32'h0});
        tick();
        check("add_t4", {cur_s.grc, cur_s.rout, cur_s.alu, cur_s.ren}, {1'b1, 1'b1, ALU_ADD, Z_B});
        tick();
        check("add_t5", {cur_s.enc, cur_s.gra, cur_s.rin, cur_s.done}, {Z_B, 1'b1, 1'b1, 1'b1});
        tick();
        check("add_then_t0", {cur_s.enc, cur_s.ren, cur_s.inc}, {PC_B, MAR_B, 1'b1});

        run_instr(OP_SUB, 1'b0, 6, "sub");
        check("sub_alu", 96'(snap[4].alu), 96'(ALU_SUB));
        run_instr(OP_OR, 1'b0, 6, "or");
        check("or_alu", 96'(snap[4].alu), 96'(ALU_OR));
        run_instr(OP_LDI, 1'b0, 6, "ldi");
        check("ldi_t3", {snap[3].grb, snap[3].baout, snap[3].rout, snap[3].ren}, {1'b1, 1'b1, 1'b0, Y_B});
        check("ldi_t4", {snap[4].enc, snap[4].alu, snap[4].ren}, {C_B, ALU_ADD, Z_B});

        run_instr(OP_BR, 1'b1, 7, "br_taken");
        check("br_t3", {snap[3].gra, snap[3].rout, snap[3].conin}, 3'b111);
        check("br_t4", {snap[4].enc, snap[4].ren}, {PC_B, Y_B});
        check("br_t5", {snap[5].enc, snap[5].ren, snap[5].alu}, {C_B, Z_B, ALU_ADD});
        check("br_taken_t6", {snap[6].enc, snap[6].ren}, {Z_B, PC_B});
        run_instr(OP_BR, 1'b0, 7, "br_not");
        check("br_not_t6", {snap[6].enc, snap[6].ren}, 64'h0);

        run_instr(OP_JAL, 1'b0, 5, "jal");
        check("jal_t3", {snap[3].enc, snap[3].grb, snap[3].rin}, {PC_B, 1'b1, 1'b1});
        check("jal_t4", {snap[4].gra, snap[4].rout, snap[4].ren}, {1'b1, 1'b1, PC_B});
        run_instr(OP_JR, 1'b0, 4, "jr");
        check("jr_t3", {snap[3].gra, snap[3].rout, snap[3].ren}, {1'b1, 1'b1, PC_B});

        run_instr(OP_LD, 1'b0, 8, "ld");
        check("ld_t5", {snap[5].enc, snap[5].ren}, {Z_B, MAR_B});
        check("ld_t7", {snap[7].enc, snap[7].gra, snap[7].rin}, {MDR_B, 1'b1, 1'b1});

        run_instr(OP_ST, 1'b0, 8, "st");
        wr_seen = 0;
        for (int i = 0; i < 7; i++) wr_seen += int'(snap[i].wr);
        check("st_write_early", 96'(wr_seen), 96'd0);
        check("st_t6", {snap[6].gra, snap[6].rout, snap[6].rd, snap[6].ren}, {1'b1, 1'b1, 1'b0, MDR_B});
        check("st_t7_write", 96'(snap[7].wr), 96'd1);

        // Second st abandoned by reset during T6
        ir = {OP_ST, 27'h0};
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            wr_seen += int'(write);
        end
        check("st2_at_t6", {cur_s.gra, cur_s.rout, cur_s.ren}, {1'b1, 1'b1, MDR_B});
        clr = 1'b0;
        tick();
        wr_seen += int'(write);
        check("st2_reset_outputs", cur_s, 96'h0);
        clr = 1'b1;
        tick();
        wr_seen += int'(write);
        tick();
        check("st2_restart_t0", {cur_s.enc, cur_s.ren, cur_s.inc}, {PC_B, MAR_B, 1'b1});
        check("st2_no_write", 96'(wr_seen), 96'd0);

        // halt holds until reset, regardless of ir
        ir = {OP_HALT, 27'h0};
        tick(); tick(); tick();
        ir = 32'h0;
        hc = 0;
        for (int i = 0; i < 20; i++) begin
            if (cur_s == snap_t'(82'd1)) hc++;
            tick();
        end
        check("halt_held_20", 96'(hc), 96'd20);
        clr = 1'b0;
        tick();
        check("halt_reset", cur_s, 96'h0);
        clr = 1'b1;
        tick(); tick();
        check("halt_restart_t0", {cur_s.enc, cur_s.ren, cur_s.inc}, {PC_B, MAR_B, 1'b1});

        run_instr(5'b11111, 1'b0, 4, "undef");
        check("undef_t3", snap[3], 96'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
